// File: rtl/decoded_instr_queue_if.sv
// Decoded-entry types and the issue-path handshake interface.
//
// ariane_pkg     : scoreboard_entry_t, the decoded instruction record carried
//                  from decode to issue.
// decoded_instr_queue_if
//   decode side  : issue_entry_i, issue_entry_valid_i, is_ctrl_flow_i,
//                  issue_instr_ack_o (accept)
//   issue side   : issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o,
//                  issue_instr_ack_i (consume), next_entry_o,
//                  next_entry_valid_o (lookahead at head+1)
//   modports     : slave  = the queue itself
//                  master = the surrounding decode/issue stages
package ariane_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  fu;
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        valid;
  } scoreboard_entry_t;
endpackage

interface decoded_instr_queue_if;
  import ariane_pkg::*;

  scoreboard_entry_t issue_entry_i;
  logic              issue_entry_valid_i;
  logic              is_ctrl_flow_i;
  logic              issue_instr_ack_o;

  scoreboard_entry_t issue_entry_o;
  logic              issue_entry_valid_o;
  logic              is_ctrl_flow_o;
  logic              issue_instr_ack_i;
  scoreboard_entry_t next_entry_o;
  logic              next_entry_valid_o;

  modport slave (
    input  issue_entry_i, issue_entry_valid_i, is_ctrl_flow_i, issue_instr_ack_i,
    output issue_instr_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o,
           next_entry_o, next_entry_valid_o
  );

  modport master (
    output issue_entry_i, issue_entry_valid_i, is_ctrl_flow_i, issue_instr_ack_i,
    input  issue_instr_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o,
           next_entry_o, next_entry_valid_o
  );
endinterface

// File: rtl/decoded_instr_queue.sv
// Registered FIFO of decoded scoreboard entries between decode and issue.
// Sustains one enqueue and one dequeue per cycle, exposes the entry behind
// the head as a lookahead, empties on flush and stops intake on debug request.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset (clears pointers, count, storage)
//   flush_i      drop every entry; nothing is accepted or presented this cycle
//   debug_req_i  block intake; draining continues
//   q            issue-path handshake (decode side in, issue side out)
//   count_o      number of occupied entries
module decoded_instr_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         debug_req_i,
  decoded_instr_queue_if.slave         q,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef struct packed {
    scoreboard_entry_t sbe;
    logic              is_ctrl_flow;
  } rec_t;

  rec_t          mem [DEPTH];
  logic [PW-1:0] rptr, wptr, rptr_nxt;
  logic [CW-1:0] count;
  logic          full, enq, deq;

  // DEPTH need not be a power of two, so wrap by explicit compare.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign rptr_nxt = ptr_inc(rptr);
  assign full     = (count == CW'(DEPTH));

  // Intake ignores the same-cycle dequeue so the accept path stays
  // independent of downstream back-pressure.
  assign enq = q.issue_entry_valid_i & ~full & ~debug_req_i & ~flush_i;
  assign deq = q.issue_instr_ack_i & q.issue_entry_valid_o & ~flush_i;

  assign q.issue_instr_ack_o   = enq;
  assign q.issue_entry_o       = mem[rptr].sbe;
  assign q.is_ctrl_flow_o      = mem[rptr].is_ctrl_flow;
  assign q.issue_entry_valid_o = (count != '0) & ~flush_i;
  assign q.next_entry_o        = mem[rptr_nxt].sbe;
  assign q.next_entry_valid_o  = (count >= CW'(2)) & ~flush_i;
  assign count_o               = count;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      // Storage is left as is; only the bookkeeping restarts.
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        mem[wptr] <= '{sbe: q.issue_entry_i, is_ctrl_flow: q.is_ctrl_flow_i};
        wptr      <= ptr_inc(wptr);
      end
      if (deq) rptr <= rptr_nxt;
      count <= count + CW'(enq) - CW'(deq);
    end
  end

endmodule

// File: tb/tb_decoded_instr_queue.sv
module tb_decoded_instr_queue;
  import ariane_pkg::*;

  logic clk = 1'b0;
  logic rst_ni, flush_i, debug_req_i;
  logic flush3, debug3;
  logic [2:0] count4;
  logic [1:0] count3;

  always #5 clk = ~clk;

  decoded_instr_queue_if q4 ();
  decoded_instr_queue_if q3 ();

  decoded_instr_queue #(.DEPTH(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .debug_req_i(debug_req_i),
    .q(q4), .count_o(count4)
  );

  decoded_instr_queue #(.DEPTH(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush3), .debug_req_i(debug3),
    .q(q3), .count_o(count3)
  );

  int errors = 0;
  int checks = 0;

  function automatic scoreboard_entry_t mk(input int tag);
    scoreboard_entry_t e;
    e.pc    = 32'h1000 + 32'(tag) * 4;
    e.fu    = 4'(tag);
    e.op    = 7'(tag * 3);
    e.rs1   = 5'(tag);
    e.rs2   = 5'(tag + 1);
    e.rd    = 5'(tag + 2);
    e.imm   = ~32'(tag);
    e.valid = 1'b1;
    return e;
  endfunction

  function automatic logic cf(input int tag);
    return tag[0];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic v, ack, fl, dbg;
    int   tag;
    logic e_ack, e_hv, e_nv;
    int   e_htag, e_ntag, e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t V(input logic v, ack, fl, dbg, input int tag,
                             input logic e_ack, e_hv, input int e_htag,
                             input logic e_nv, input int e_ntag, input int e_cnt);
    vec_t r;
    r.v = v; r.ack = ack; r.fl = fl; r.dbg = dbg; r.tag = tag;
    r.e_ack = e_ack; r.e_hv = e_hv; r.e_htag = e_htag;
    r.e_nv = e_nv; r.e_ntag = e_ntag; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic drive4(input logic v, ack, fl, dbg, input int tag);
    q4.issue_entry_valid_i = v;
    q4.issue_entry_i       = mk(tag);
    q4.is_ctrl_flow_i      = cf(tag);
    q4.issue_instr_ack_i   = ack;
    flush_i                = fl;
    debug_req_i            = dbg;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_cnt"},   128'(count4), 128'(0));
    chk({tag, "_hv"},    128'(q4.issue_entry_valid_o), 128'(0));
    chk({tag, "_nv"},    128'(q4.next_entry_valid_o), 128'(0));
    chk({tag, "_head"},  128'(q4.issue_entry_o), 128'(0));
    chk({tag, "_next"},  128'(q4.next_entry_o), 128'(0));
    chk({tag, "_cf"},    128'(q4.is_ctrl_flow_o), 128'(0));
  endtask

  initial begin
    rst_ni = 1'b0;
    drive4(1'b0, 1'b0, 1'b0, 1'b0, 0);
    q3.issue_entry_valid_i = 1'b0;
    q3.issue_entry_i       = '0;
    q3.is_ctrl_flow_i      = 1'b0;
    q3.issue_instr_ack_i   = 1'b0;
    flush3 = 1'b0;
    debug3 = 1'b0;
    tick();
    tick();
    check_reset_state("rst");
    chk("rst_ack", 128'(q4.issue_instr_ack_o), 128'(0));
    chk("rst_cnt3", 128'(count3), 128'(0));
    rst_ni = 1'b1;

    //            v ack fl dbg tag  eack hv htag nv ntag cnt
    // fill A..D, E refused while full
    vecs.push_back(V(1, 0, 0, 0, 1,  1, 0, 0,  0, 0, 0));
    vecs.push_back(V(1, 0, 0, 0, 2,  1, 1, 1,  0, 0, 1));
    vecs.push_back(V(1, 0, 0, 0, 3,  1, 1, 1,  1, 2, 2));
    vecs.push_back(V(1, 0, 0, 0, 4,  1, 1, 1,  1, 2, 3));
    vecs.push_back(V(1, 0, 0, 0, 5,  0, 1, 1,  1, 2, 4));
    // drain in order with lookahead
    vecs.push_back(V(0, 1, 0, 0, 0,  0, 1, 1,  1, 2, 4));
    vecs.push_back(V(0, 1, 0, 0, 0,  0, 1, 2,  1, 3, 3));
    vecs.push_back(V(0, 1, 0, 0, 0,  0, 1, 3,  1, 4, 2));
    vecs.push_back(V(0, 1, 0, 0, 0,  0, 1, 4,  0, 0, 1));
    // ack while empty is ignored
    vecs.push_back(V(0, 1, 0, 0, 0,  0, 0, 0,  0, 0, 0));
    vecs.push_back(V(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0));
    // refill across the pointer wrap, then full with simultaneous deq
    vecs.push_back(V(1, 0, 0, 0, 6,  1, 0, 0,  0, 0, 0));
    vecs.push_back(V(1, 0, 0, 0, 7,  1, 1, 6,  0, 0, 1));
    vecs.push_back(V(1, 0, 0, 0, 8,  1, 1, 6,  1, 7, 2));
    vecs.push_back(V(1, 0, 0, 0, 9,  1, 1, 6,  1, 7, 3));
    vecs.push_back(V(1, 1, 0, 0, 10, 0, 1, 6,  1, 7, 4));
    vecs.push_back(V(1, 0, 0, 0, 10, 1, 1, 7,  1, 8, 3));
    vecs.push_back(V(0, 1, 0, 0, 0,  0, 1, 7,  1, 8, 4));
    // flush with 3 entries and a valid input
    vecs.push_back(V(1, 1, 1, 0, 11, 0, 0, 0,  0, 0, 3));
    vecs.push_back(V(1, 0, 0, 0, 12, 1, 0, 0,  0, 0, 0));
    vecs.push_back(V(0, 0, 0, 0, 0,  0, 1, 12, 0, 0, 1));
    // debug request: intake blocked, queue drains
    vecs.push_back(V(1, 0, 0, 0, 13, 1, 1, 12, 0, 0, 1));
    vecs.push_back(V(1, 1, 0, 1, 14, 0, 1, 12, 1, 13, 2));
    vecs.push_back(V(1, 1, 0, 1, 14, 0, 1, 13, 0, 0, 1));
    vecs.push_back(V(1, 1, 0, 1, 14, 0, 0, 0,  0, 0, 0));
    vecs.push_back(V(1, 1, 0, 1, 14, 0, 0, 0,  0, 0, 0));
    vecs.push_back(V(1, 0, 0, 0, 14, 1, 0, 0,  0, 0, 0));
    vecs.push_back(V(1, 0, 0, 0, 15, 1, 1, 14, 0, 0, 1));
    vecs.push_back(V(0, 0, 0, 0, 0,  0, 1, 14, 1, 15, 2));

    foreach (vecs[i]) begin
      string n;
      n = $sformatf("v%0d", i);
      drive4(vecs[i].v, vecs[i].ack, vecs[i].fl, vecs[i].dbg, vecs[i].tag);
      #1;
      chk({n, "_ack"}, 128'(q4.issue_instr_ack_o), 128'(vecs[i].e_ack));
      chk({n, "_hv"},  128'(q4.issue_entry_valid_o), 128'(vecs[i].e_hv));
      chk({n, "_nv"},  128'(q4.next_entry_valid_o), 128'(vecs[i].e_nv));
      chk({n, "_cnt"}, 128'(count4), 128'(vecs[i].e_cnt));
      if (vecs[i].e_hv) begin
        chk({n, "_head"}, 128'(q4.issue_entry_o), 128'(mk(vecs[i].e_htag)));
        chk({n, "_cf"},   128'(q4.is_ctrl_flow_o), 128'(cf(vecs[i].e_htag)));
      end
      if (vecs[i].e_nv)
        chk({n, "_next"}, 128'(q4.next_entry_o), 128'(mk(vecs[i].e_ntag)));
      tick();
    end

    // Glitch on rst_ni between edges must not disturb the queue (count=2).
    drive4(1'b0, 1'b0, 1'b0, 1'b0, 0);
    #1 rst_ni = 1'b0;
    #2 rst_ni = 1'b1;
    tick();
    chk("glitch_cnt",  128'(count4), 128'(2));
    chk("glitch_head", 128'(q4.issue_entry_o), 128'(mk(14)));

    // Synchronous reset for one edge with a valid input: reset wins.
    drive4(1'b1, 1'b0, 1'b0, 1'b0, 20);
    rst_ni = 1'b0;
    tick();
    drive4(1'b0, 1'b0, 1'b0, 1'b0, 0);
    rst_ni = 1'b1;
    #1;
    check_reset_state("mrst");
    tick();
    chk("mrst_cnt_hold", 128'(count4), 128'(0));

    // Streaming through the DEPTH=3 queue: wraps 2->0 several times.
    begin
      int deqs = 0;
      q3.issue_entry_valid_i = 1'b1;
      q3.issue_instr_ack_i   = 1'b1;
      for (int i = 0; i < 20; i++) begin
        q3.issue_entry_i  = mk(100 + i);
        q3.is_ctrl_flow_i = cf(100 + i);
        #1;
        chk($sformatf("s%0d_ack", i), 128'(q3.issue_instr_ack_o), 128'(1));
        chk($sformatf("s%0d_cnt", i), 128'(count3), 128'(i == 0 ? 0 : 1));
        if (i > 0) begin
          chk($sformatf("s%0d_head", i), 128'(q3.issue_entry_o), 128'(mk(99 + i)));
          chk($sformatf("s%0d_cf", i), 128'(q3.is_ctrl_flow_o), 128'(cf(99 + i)));
        end
        if (q3.issue_entry_valid_o) deqs++;
        tick();
      end
      q3.issue_entry_valid_i = 1'b0;
      q3.issue_instr_ack_i   = 1'b0;
      #1;
      chk("s_deqs", 128'(deqs), 128'(19));
      chk("s_last", 128'(q3.issue_entry_o), 128'(mk(119)));
      chk("s_cnt_end", 128'(count3), 128'(1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoded_instr_queue.md
# decoded_instr_queue

Registered FIFO of decoded scoreboard entries between the decode stage and the instruction reordering stage. It decouples decode from issue back-pressure and sustains one entry per cycle. It also exposes the entry behind the head (lookahead) so the reordering stage can inspect the next instruction without consuming it. Flush empties the queue; a debug request stops intake while the queue drains.

## Interface
Parameters:
- DEPTH, 4, number of entries; legal values 2..16, need not be a power of two.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset; synchronous and active-low.
- flush_i  in  1  discard all entries.
- debug_req_i  in  1  when high, no new entry is accepted.
- issue_entry_i  in  ariane_pkg::scoreboard_entry_t  decoded entry from the decode stage.
- issue_entry_valid_i  in  1  issue_entry_i is valid.
- is_ctrl_flow_i  in  1  entry is a control-flow instruction.
- issue_instr_ack_o  out  1  entry on the inputs is accepted this cycle.
- issue_entry_o  out  ariane_pkg::scoreboard_entry_t  head entry.
- issue_entry_valid_o  out  1  head is valid.
- is_ctrl_flow_o  out  1  head control-flow flag.
- issue_instr_ack_i  in  1  downstream consumes the head this cycle.
- next_entry_o  out  ariane_pkg::scoreboard_entry_t  entry at head+1 (lookahead).
- next_entry_valid_o  out  1  lookahead entry is valid.
- count_o  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- State:
  - storage array of DEPTH records {sbe, is_ctrl_flow};
  - read pointer rptr and write pointer wptr, each $clog2(DEPTH) bits;
  - count, $clog2(DEPTH+1) bits.
- Pointer wrap: a pointer increments modulo DEPTH, i.e. DEPTH-1 goes to 0. Explicit compare is required because DEPTH may be a non-power-of-two.
- enq = issue_entry_valid_i & (count != DEPTH) & !debug_req_i & !flush_i.
- issue_instr_ack_o = enq, combinational. It must not depend on issue_instr_ack_i; no enqueue into a full queue even when a dequeue occurs the same cycle.
- deq = issue_instr_ack_i & issue_entry_valid_o & !flush_i. An ack_i while the queue is empty is ignored.
- On enq:
  - storage[wptr] <= {issue_entry_i, is_ctrl_flow_i};
  - wptr advances.
- On deq: rptr advances.
- count next value: count + enq - deq. Simultaneous enq and deq leaves count unchanged.
- Head outputs:
  - issue_entry_o = storage[rptr];
  - is_ctrl_flow_o = storage[rptr].is_ctrl_flow;
  - issue_entry_valid_o = (count != 0) & !flush_i.
- Lookahead outputs:
  - next_entry_o = storage[(rptr+1) mod DEPTH];
  - next_entry_valid_o = (count >= 2) & !flush_i.
- count_o = count.
- Flush:
  - in the flush cycle, enq = deq = 0 and both valid outputs are 0;
  - next cycle: rptr = wptr = count = 0;
  - storage contents are not cleared by flush.
- Reset (rst_ni low at a rising edge):
  - rptr = wptr = count = 0;
  - all storage records = '0.
  - Reset takes priority over flush and enqueue.
- debug_req_i blocks only intake. Draining continues and the ack_i semantics are unchanged.

## Timing
- Reset values of all outputs:
  - issue_instr_ack_o follows its combinational equation;
  - issue_entry_valid_o = next_entry_valid_o = 0;
  - issue_entry_o = next_entry_o = '0;
  - is_ctrl_flow_o = 0;
  - count_o = 0.
- Latency: an entry enqueued at edge N appears on issue_entry_o (if the queue was empty) at N+1. There is no input-to-output bypass.
- Throughput: one enq and one deq per cycle.
- Upstream must hold issue_entry_i stable until issue_instr_ack_o is high. Downstream samples the head in the same cycle it asserts issue_instr_ack_i.
- Full: count == DEPTH forces issue_instr_ack_o = 0 for that whole cycle. A deq in that cycle frees a slot for the next cycle.
- Empty: issue_entry_valid_o = 0. The first enq becomes visible one cycle later.
- Wrap: the lookahead index wraps identically to the pointers.
- Flush together with valid input: the input is not acked and must be re-presented after the flush.
- Reset mid-operation: all entries are lost and the queue restarts empty.

## Test plan
- Fill and drain with DEPTH=4, ack_i=0: present entries A,B,C,D,E back-to-back -> acks for A–D; count_o goes 1,2,3,4; E is not acked. Then ack_i=1 -> heads A,B,C,D in order, and next_entry_o shows B,C,D at the respective heads.
- Streaming: valid_i and ack_i high for 20 cycles with DEPTH=3 -> count_o holds at 1 after the first cycle, order is preserved, wrap of rptr/wptr crosses 2→0 without loss.
- Full plus simultaneous deq: count=4, ack_i=1, valid_i=1 -> issue_instr_ack_o=0 that cycle, count_o=3 next cycle; the input is acked in the following cycle.
- Flush with 3 entries and valid_i=1 -> issue_instr_ack_o=0 and both valid outputs 0 during flush; next cycle count_o=0; a new entry X enqueued afterwards appears as head one cycle later.
- debug_req_i high with 2 entries, ack_i=1, valid_i=1 -> no acks; both entries drain; count_o reaches 0 and stays 0 until debug_req_i drops.
- Synchronous reset at mid-fill, rst_ni low for one edge with count=2 -> next cycle count_o=0, valid outputs 0, issue_entry_o='0. Asynchronous glitches of rst_ni between edges have no effect.
